// File: rtl/weight_buf_rd_stream.sv
// Weight buffer: DMA write port into on-chip RAM, plus a windowed read stream
// to the PE array through a 2-entry skid FIFO that hides the RAM read latency.
module weight_buf_rd_stream #(
  parameter int BUF_ADDR_W = 16,
  parameter int DATA_W     = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dma_wr_en,
  input  logic [BUF_ADDR_W-1:0] dma_wr_addr,
  input  logic [DATA_W-1:0]     dma_wr_data,
  input  logic                  rd_start,
  input  logic [BUF_ADDR_W-1:0] rd_base,
  input  logic [16:0]           rd_len,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_W-1:0]     w_data,
  output logic                  w_last
);

  localparam int DEPTH = 1 << BUF_ADDR_W;

  // state  | meaning
  // IDLE   | waiting for rd_start
  // STREAM | issuing RAM reads and draining the skid FIFO
  // DONE   | one-cycle rd_done pulse
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state, next_state;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_q;
  logic [BUF_ADDR_W-1:0] rd_ptr;
  logic [16:0]           issued, accepted, eff_len, eff_len_c;
  logic                  inflight, rd_last_q;
  logic                  issue, load, push, pop;
  logic [DATA_W-1:0]     slot_data [2];
  logic [1:0]            slot_last;
  logic                  wp, rp;
  logic [1:0]            count;
  logic [2:0]            occ, lim;

  always_ff @(posedge clk) begin
    if (dma_wr_en) mem[dma_wr_addr] <= dma_wr_data;
    if (issue)     rd_q <= mem[rd_ptr];
  end

  always_comb begin
    eff_len_c = ({15'd0, rd_len} > 32'(DEPTH)) ? 17'(DEPTH) : rd_len;
    push      = inflight;
    pop       = (count != 2'd0) && w_ready;
    occ       = {1'b0, count} + {2'b00, inflight};
    // A word leaving this edge frees a slot, which keeps one word per cycle.
    lim       = 3'd2 + {2'b00, pop};
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) begin
          load       = 1'b1;
          next_state = (eff_len_c == 17'd0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        issue = (occ < lim) && (issued < eff_len);
        if (pop && (17'(accepted + 17'd1) == eff_len)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      issued    <= '0;
      accepted  <= '0;
      eff_len   <= '0;
      inflight  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      inflight  <= issue;
      rd_last_q <= issue && (17'(issued + 17'd1) == eff_len);
      if (load) begin
        rd_ptr   <= rd_base;
        issued   <= '0;
        accepted <= '0;
        eff_len  <= eff_len_c;
      end else begin
        if (issue) begin
          rd_ptr <= rd_ptr + {{(BUF_ADDR_W-1){1'b0}}, 1'b1};
          issued <= issued + 17'd1;
        end
        if (pop) accepted <= accepted + 17'd1;
      end
    end
  end

  // Slots are written only on push and read only at rp, so the head holds until popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_data[0] <= '0;
      slot_data[1] <= '0;
      slot_last    <= '0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      count        <= '0;
    end else begin
      if (push) begin
        slot_data[wp] <= rd_q;
        slot_last[wp] <= rd_last_q;
        wp            <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rd_busy = (state == STREAM);
  assign rd_done = (state == DONE);
  assign w_valid = (count != 2'd0);
  assign w_data  = slot_data[rp];
  assign w_last  = w_valid && slot_last[rp];

endmodule

// File: tb/tb_weight_buf_rd_stream.sv
// Directed bench for weight_buf_rd_stream: streams, stalls, wrap, clamp,
// ignored restart and mid-stream reset.
module tb_weight_buf_rd_stream;

  localparam int DEPTH = 1 << 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dma_wr_en = 1'b0;
  logic [15:0]  dma_wr_addr = '0;
  logic [127:0] dma_wr_data = '0;
  logic         rd_start = 1'b0;
  logic [15:0]  rd_base = '0;
  logic [16:0]  rd_len = '0;
  logic         rd_busy, rd_done, w_valid, w_last;
  logic         w_ready = 1'b0;
  logic [127:0] w_data;

  int checks = 0;
  int errors = 0;
  logic [127:0] model [int];

  weight_buf_rd_stream dut (
    .clk(clk), .rst_n(rst_n),
    .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [127:0] d);
    @(negedge clk);
    dma_wr_en = 1'b1; dma_wr_addr = a; dma_wr_data = d;
    model[int'(a)] = d;
  endtask

  task automatic wr_end();
    @(negedge clk);
    dma_wr_en = 1'b0;
  endtask

  // cyc 0 is the first negedge after the edge that samples rd_start.
  task automatic run_stream(input string name, input logic [15:0] base, input logic [16:0] len,
                            input int n_exp, input bit rnd, input bit poke,
                            output int first_v, output int done_c);
    int hs, dones, cyc;
    logic [15:0] a;
    logic stall, held_last;
    logic [127:0] held;
    hs = 0; dones = 0; cyc = 0; a = base; stall = 1'b0;
    held = '0; held_last = 1'b0; first_v = -1; done_c = -1;
    @(negedge clk);
    rd_start = 1'b1; rd_base = base; rd_len = len;
    @(negedge clk);
    rd_start = 1'b0;
    while (dones == 0 && cyc < n_exp * 4 + 20) begin
      if (rd_done) begin dones++; done_c = cyc; end
      if (w_valid && first_v < 0) first_v = cyc;
      if (stall) begin
        chk({name, "_stall_valid"}, 128'(w_valid), 128'(1));
        chk({name, "_stall_data"}, w_data, held);
        chk({name, "_stall_last"}, 128'(w_last), 128'(held_last));
      end
      held = w_data; held_last = w_last;
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_start = poke && (cyc == 3);
      rd_base = 16'd100; rd_len = 17'd9;
      if (w_valid && w_ready) begin
        hs++;
        if (model.exists(int'(a))) chk({name, "_data"}, w_data, model[int'(a)]);
        chk({name, "_last"}, 128'(w_last), 128'(hs == n_exp));
        a = a + 16'd1;
        stall = 1'b0;
      end else begin
        stall = w_valid;
      end
      @(negedge clk);
      cyc++;
    end
    rd_start = 1'b0;
    chk({name, "_done_pulses"}, 128'(dones), 128'(1));
    chk({name, "_handshakes"}, 128'(hs), 128'(n_exp));
    chk({name, "_done_low_after"}, 128'(rd_done), 128'(0));
    chk({name, "_busy_low_after"}, 128'(rd_busy), 128'(0));
    chk({name, "_valid_low_after"}, 128'(w_valid), 128'(0));
  endtask

  initial begin
    int fv, dc, hs, cyc;

    #12;
    chk("reset_busy", 128'(rd_busy), 128'(0));
    chk("reset_done", 128'(rd_done), 128'(0));
    chk("reset_valid", 128'(w_valid), 128'(0));
    chk("reset_last", 128'(w_last), 128'(0));
    chk("reset_data", w_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) wr(16'(i), 128'(8'hA0 + i));
    wr(16'(DEPTH - 2), 128'hB0);
    wr(16'(DEPTH - 1), 128'hB1);
    wr_end();

    run_stream("basic", 16'd0, 17'd4, 4, 1'b0, 1'b0, fv, dc);
    chk("basic_first_valid_cyc", 128'(fv), 128'(2));
    chk("basic_done_cyc", 128'(dc), 128'(6));

    run_stream("stall", 16'd0, 17'd4, 4, 1'b1, 1'b0, fv, dc);
    chk("stall_first_valid_cyc", 128'(fv), 128'(2));

    run_stream("wrap", 16'(DEPTH - 2), 17'd4, 4, 1'b0, 1'b0, fv, dc);
    chk("wrap_done_cyc", 128'(dc), 128'(6));

    run_stream("zero", 16'd0, 17'd0, 0, 1'b0, 1'b0, fv, dc);
    chk("zero_done_cyc", 128'(dc), 128'(0));
    chk("zero_no_valid", 128'(fv), 128'(-1));

    run_stream("restart", 16'd2, 17'd6, 6, 1'b0, 1'b1, fv, dc);
    chk("restart_done_cyc", 128'(dc), 128'(8));

    run_stream("clamp", 16'd0, 17'(DEPTH + 5), DEPTH, 1'b0, 1'b0, fv, dc);
    chk("clamp_done_cyc", 128'(dc), 128'(DEPTH + 2));

    // Reset after two of eight words have been accepted.
    @(negedge clk);
    rd_start = 1'b1; rd_base = 16'd0; rd_len = 17'd8; w_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      if (w_valid && w_ready) hs++;
      if (hs < 2) @(negedge clk);
      cyc++;
    end
    chk("rst_two_words_seen", 128'(hs), 128'(2));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 128'(rd_busy), 128'(0));
    chk("rst_done", 128'(rd_done), 128'(0));
    chk("rst_valid", 128'(w_valid), 128'(0));
    chk("rst_last", 128'(w_last), 128'(0));
    chk("rst_data", w_data, 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_done", 128'(rd_done), 128'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 128'(rd_done), 128'(0));
      chk("post_rst_valid", 128'(w_valid), 128'(0));
    end

    run_stream("after_rst", 16'd0, 17'd8, 8, 1'b0, 1'b0, fv, dc);
    chk("after_rst_done_cyc", 128'(dc), 128'(10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
